// File: rtl/snake_pkg.sv
// Shared definitions for the keypad front end and snake_core:
// direction key codes, debounce FSM encoding and small row-decode helpers.
package snake_pkg;

   localparam logic [3:0] KEY_UP    = 4'h6;
   localparam logic [3:0] KEY_DOWN  = 4'h4;
   localparam logic [3:0] KEY_LEFT  = 4'h8;
   localparam logic [3:0] KEY_RIGHT = 4'h2;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } kp_state_e;

   // Index of the lowest pressed row; rows is active-high here.
   function automatic logic [1:0] lowest_row(input logic [3:0] rows);
      if (rows[0])      return 2'd0;
      else if (rows[1]) return 2'd1;
      else if (rows[2]) return 2'd2;
      else              return 2'd3;
   endfunction

   function automatic logic multi_hot(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the key-event outputs consumed by snake_core.
// key_pressed is a one-cycle strobe with no ready: the consumer must take it that cycle.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_val;
   logic       key_pressed;
   logic       key_down;

   modport slave (
      input  row_n,
      output col_n, key_val, key_pressed, key_down
   );

   modport master (
      output row_n,
      input  col_n, key_val, key_pressed, key_down
   );
endinterface

// File: rtl/keypad_frame_scan.sv
// Column scanner: synchronises rows, walks the columns and condenses each
// 4-column sweep into one frame summary (any / multi / first key code).
module keypad_frame_scan
   import snake_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic       frame_done,
   output logic       frame_any,
   output logic       frame_multi,
   output logic [3:0] frame_code
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [3:0]       row_meta_q, row_sync_q;
   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       col_idx_q, col_idx_d;
   logic [3:0]       col_n_q, col_n_d;
   logic             acc_any_q, acc_any_d;
   logic             acc_multi_q, acc_multi_d;
   logic [3:0]       acc_code_q, acc_code_d;

   logic [3:0] rows;
   logic       sample;
   logic       slot_any;

   always_comb begin
      rows        = ~row_sync_q;
      sample      = (div_q == DIV_LAST);
      slot_any    = |rows;
      div_d       = sample ? '0 : div_q + 1'b1;
      col_idx_d   = col_idx_q;
      col_n_d     = col_n_q;
      acc_any_d   = acc_any_q;
      acc_multi_d = acc_multi_q;
      acc_code_d  = acc_code_q;

      // Merged view of the accumulator plus the slot being sampled now.
      frame_any   = acc_any_q | slot_any;
      frame_multi = acc_multi_q | multi_hot(rows) | (acc_any_q & slot_any);
      frame_code  = acc_any_q ? acc_code_q : {lowest_row(rows), col_idx_q};
      frame_done  = sample && (col_idx_q == 2'd3);

      if (sample) begin
         col_idx_d = col_idx_q + 2'd1;
         col_n_d   = ~(4'b0001 << col_idx_d);
         if (col_idx_q == 2'd3) begin
            acc_any_d   = 1'b0;
            acc_multi_d = 1'b0;
            acc_code_d  = 4'h0;
         end else begin
            acc_any_d   = frame_any;
            acc_multi_d = frame_multi;
            acc_code_d  = frame_code;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_q  <= 4'hF;
         row_sync_q  <= 4'hF;
         div_q       <= '0;
         col_idx_q   <= 2'd0;
         col_n_q     <= 4'b1110;
         acc_any_q   <= 1'b0;
         acc_multi_q <= 1'b0;
         acc_code_q  <= 4'h0;
      end else begin
         row_meta_q  <= row_n;
         row_sync_q  <= row_meta_q;
         div_q       <= div_d;
         col_idx_q   <= col_idx_d;
         col_n_q     <= col_n_d;
         acc_any_q   <= acc_any_d;
         acc_multi_q <= acc_multi_d;
         acc_code_q  <= acc_code_d;
      end
   end

   assign col_n = col_n_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: frame scanner plus a frame-rate debounce FSM that
// emits exactly one key_pressed strobe per physical press, never auto-repeating.
module keypad_scanner
   import snake_pkg::*;
#(
   parameter int SCAN_DIV        = 50000,
   parameter int DEBOUNCE_FRAMES = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   keypad_scanner_if.slave         bus,
   output kp_state_e               dbg_state
);

   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_FRAMES);

   logic       frame_done, frame_any, frame_multi;
   logic [3:0] frame_code;

   kp_state_e  state_q, state_d;
   logic [3:0] cand_q, cand_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] key_val_q, key_val_d;
   logic       key_pressed_q, key_pressed_d;
   logic       single;

   keypad_frame_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_n       (bus.row_n),
      .col_n       (bus.col_n),
      .frame_done  (frame_done),
      .frame_any   (frame_any),
      .frame_multi (frame_multi),
      .frame_code  (frame_code)
   );

   always_comb begin
      state_d       = state_q;
      cand_d        = cand_q;
      cnt_d         = cnt_q;
      key_val_d     = key_val_q;
      key_pressed_d = 1'b0;
      single        = frame_any && !frame_multi;

      if (frame_done) begin
         unique case (state_q)
            IDLE: begin
               if (single) begin
                  cand_d  = frame_code;
                  cnt_d   = 4'd1;
                  state_d = PRESS_DB;
               end
            end
            PRESS_DB: begin
               if (single && frame_code == cand_q) begin
                  if (cnt_q + 4'd1 == DB_LAST) begin
                     key_val_d     = cand_q;
                     key_pressed_d = 1'b1;
                     cnt_d         = 4'd0;
                     state_d       = HELD;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  state_d = IDLE;
               end
            end
            // Any key activity while held, even a different key, just keeps us held.
            HELD: begin
               if (!frame_any) begin
                  cnt_d   = 4'd1;
                  state_d = RELEASE_DB;
               end
            end
            RELEASE_DB: begin
               if (!frame_any) begin
                  if (cnt_q + 4'd1 == DB_LAST) begin
                     cnt_d   = 4'd0;
                     state_d = IDLE;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end else begin
                  cnt_d   = 4'd0;
                  state_d = HELD;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cand_q        <= 4'h0;
         cnt_q         <= 4'd0;
         key_val_q     <= 4'h0;
         key_pressed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cand_q        <= cand_d;
         cnt_q         <= cnt_d;
         key_val_q     <= key_val_d;
         key_pressed_q <= key_pressed_d;
      end
   end

   assign bus.key_val     = key_val_q;
   assign bus.key_pressed = key_pressed_q;
   assign bus.key_down    = (state_q == HELD) || (state_q == RELEASE_DB);
   assign dbg_state       = state_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 active-low matrix keypad and debounces it.
- Emits one-cycle key events (key_val, key_pressed) for snake_core's direction input.
- Sits between the board keypad pins and snake_core in the same 50 MHz domain.
- Scans one column at a time, collects one full 4-column "frame", and debounces across frames. Produces exactly one event per physical press, with no auto-repeat.

Parameters:
- SCAN_DIV, 50000: clocks per column slot (1 ms at 50 MHz). Must be >= 4.
- DEBOUNCE_FRAMES, 5: consecutive identical frames needed to accept a press or a release. Must be >= 2 and <= 15.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- row_n  input  4  keypad row lines, active-low, externally pulled up. Asynchronous to clk.
- col_n  output  4  keypad column drive, one-hot-low.
- key_val  output  4  code of the last accepted key, = {row[1:0], col[1:0]}, i.e. row*4+col.
- key_pressed  output  1  one-cycle strobe when key_val is updated.
- key_down  output  1  level, high while the accepted key is considered held.

Behaviour:
- Reset (async) values:
  - col_n = 4'b1110; key_val = 4'h0; key_pressed = 0; key_down = 0.
  - Row synchroniser = 4'hF; all counters = 0; FSM = IDLE.
- Input sync: row_n passes through a 2-flop synchroniser. All logic uses the synchronised value.
- Scan timing:
  - div counts 0..SCAN_DIV-1. col_idx advances 0..3 and wraps when div == SCAN_DIV-1.
  - col_n = ~(4'b0001 << col_idx), registered, changing in the same cycle col_idx changes.
- Sampling:
  - Rows are sampled only in the cycle div == SCAN_DIV-1, which gives >= 2 settle cycles past the synchroniser.
  - A pressed key in row r, column col_idx gives code {r, col_idx}.
- Frame accumulation, over slots 0..3:
  - frame_any = at least one key seen in the frame.
  - frame_multi = more than one key seen, in one slot or across slots.
  - frame_code = first key seen: lowest column, then lowest row.
  - At the sample cycle of col_idx 3, a frame_done pulse presents these values and the accumulator clears.
- FSM (advances only on frame_done; cnt is 4 bits):
  - IDLE: if frame_any && !frame_multi → cand = frame_code, cnt = 1, go to PRESS_DB. Otherwise stay.
  - PRESS_DB: if frame_any && !frame_multi && frame_code == cand, then cnt++. When cnt+1 == DEBOUNCE_FRAMES: key_val = cand, key_pressed = 1 for the next cycle only, go to HELD. Any other frame (none, multi, different code) → IDLE, cnt = 0.
  - HELD: if !frame_any → cnt = 1, go to RELEASE_DB. Any key, including a changed or multiple key, stays in HELD with no new event.
  - RELEASE_DB: if !frame_any, cnt++; when cnt+1 == DEBOUNCE_FRAMES go to IDLE. Any key → HELD.
- key_down = (state == HELD) || (state == RELEASE_DB).
- Latency: a clean press stable from the start of a frame gives key_pressed DEBOUNCE_FRAMES frames later. The strobe comes 1 cycle after the final frame_done.
- Ghosting/multi-key: a press is rejected only while the frame is multi. A single key that remains after the others are released is debounced afresh from IDLE.
- key_val holds its value until the next accepted press. It is never cleared on release.
- Reset mid-scan or mid-debounce returns everything to reset values immediately, with no pending strobe.

Decomposition:
- snake_pkg holds:
  - Key code constants KEY_UP = 4'h6, KEY_DOWN = 4'h4, KEY_LEFT = 4'h8, KEY_RIGHT = 4'h2, shared with snake_core.
  - The FSM state encoding IDLE/PRESS_DB/HELD/RELEASE_DB.
- Sub-module keypad_frame_scan: synchroniser, div/col_idx counters, col_n drive and frame accumulation. It outputs frame_done, frame_any, frame_multi and frame_code. The debounce FSM stays in keypad_scanner.

Test Plan (SCAN_DIV = 4, DEBOUNCE_FRAMES = 3, frame = 16 clk):
- Reset: hold rst_n low mid-scan, then release → col_n = 1110, key_val = 0, key_pressed = 0. Column sequence is 1110, 1101, 1011, 0111 with 4 clk each, then repeats.
- Clean press: model the keypad so row 1 goes low while column 2 is driven, held for 10 frames. Expect exactly one key_pressed pulse, key_val = 4'h6, asserted in the cycle after the 3rd frame_done containing the key. key_down is high until 3 empty frames after release.
- Bounce: key 4'h2 toggles present/absent on alternate frames for 6 frames, then is stable. Expect no strobe during the bounce, and one strobe with key_val = 2 three frames after stable.
- Multi-key: keys 4'h4 and 4'h8 held together → no strobe and key_val unchanged. Release 4'h8 → one strobe with key_val = 4 after 3 frames.
- Held with no repeat: hold 4'h8 for 50 frames, briefly drop it for 1 frame, then hold again → one strobe only, and key_down stays high.
- Reset during PRESS_DB, after 2 valid frames → no strobe. After reset the key must be debounced for a full 3 frames again.
